truth_table_sweeper: RTL

- Parametrised, self-checking exhaustive stimulus engine for an N-input, single-output combinational block.
- Steps every input pattern in binary or Gray order and holds each pattern for a programmable dwell.
- Samples the block's output at the end of each dwell and compares it against a truth-table parameter.
- Reports a pass flag, a mismatch count and the first failing pattern; used in lab benches and on-board self-test of combinational units.

---
 rtl/truth_table_sweeper_pkg.sv | 15 +
 rtl/truth_table_sweeper_bin2gray.sv | 15 +
 rtl/truth_table_sweeper.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared state encoding and width helper for the truth-table sweeper.
// Imported by the top and its pattern-mapping sub-module.
package truth_table_sweeper_pkg;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_bin2gray.sv
// Purpose: binary to reflected-Gray conversion for sweep pattern mapping.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module truth_table_sweeper_bin2gray
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] bin,
  output logic [N_IN-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/truth_table_sweeper.sv
// Purpose: exhaustive binary/Gray stimulus engine that checks a 1-output block against a truth table.
// Latency: first result N_PAT*DWELL cycles after the start edge; done pulses the cycle after.
// Backpressure: none; start is ignored while busy, abort wins over everything but reset.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int                      N_IN     = 3,
  parameter int                      DWELL    = 3,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            gray_mode,
  input  logic            continuous,
  output logic [N_IN-1:0] stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);

  localparam int              N_PAT      = 1 << N_IN;
  localparam int              DW         = (clog2(DWELL) < 1) ? 1 : clog2(DWELL);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N_IN-1:0] LAST_IDX   = N_IN'(N_PAT - 1);
  localparam logic [N_IN:0]   ERR_MAX    = (N_IN + 1)'(N_PAT);

  logic            state_q, state_d;
  logic [N_IN-1:0] idx_q;
  logic [DW-1:0]   dwell_q;
  logic [N_IN:0]   live_err_q;
  logic [N_IN-1:0] live_ff_q;
  logic            live_fv_q;
  logic            gray_q;
  logic            cont_q;

  logic [N_IN-1:0] idx_nxt;
  logic [N_IN-1:0] idx_nxt_gray;
  logic [N_IN-1:0] pat_nxt;
  logic            sample;
  logic            last;
  logic            mismatch;
  logic [N_IN:0]   err_nxt;
  logic [N_IN-1:0] ff_nxt;
  logic            fv_nxt;

  truth_table_sweeper_bin2gray #(.N_IN(N_IN)) u_bin2gray (
    .bin  (idx_nxt),
    .gray (idx_nxt_gray)
  );

  // pattern(0) is 0 in both orders, so start and wrap always drive stim=0.
  assign idx_nxt  = idx_q + N_IN'(1);
  assign pat_nxt  = gray_q ? idx_nxt_gray : idx_nxt;
  assign sample   = (dwell_q == DWELL_LAST);
  assign last     = (idx_q == LAST_IDX);
  assign mismatch = (dut_y != EXPECTED[stim]);
  assign err_nxt  = (mismatch && (live_err_q != ERR_MAX)) ? live_err_q + (N_IN + 1)'(1) : live_err_q;
  assign ff_nxt   = (mismatch && !live_fv_q) ? stim : live_ff_q;
  assign fv_nxt   = live_fv_q | mismatch;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)                         state_d = S_IDLE;
        else if (sample && last && !cont_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      dwell_q    <= '0;
      stim       <= '0;
      live_err_q <= '0;
      live_ff_q  <= '0;
      live_fv_q  <= 1'b0;
      gray_q     <= 1'b0;
      cont_q     <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          idx_q      <= '0;
          dwell_q    <= '0;
          stim       <= '0;
          live_err_q <= '0;
          live_ff_q  <= '0;
          live_fv_q  <= 1'b0;
          gray_q     <= gray_mode;
          cont_q     <= continuous;
        end
      end else if (abort) begin
        idx_q   <= '0;
        dwell_q <= '0;
        stim    <= '0;
      end else if (sample) begin
        dwell_q    <= '0;
        live_err_q <= err_nxt;
        live_ff_q  <= ff_nxt;
        live_fv_q  <= fv_nxt;
        if (last) begin
          pass       <= (err_nxt == '0);
          err_count  <= err_nxt;
          fail_valid <= fv_nxt;
          first_fail <= ff_nxt;
          done       <= 1'b1;
          // Back-to-back re-sweep: restart from pattern 0 with no gap cycle.
          if (cont_q) begin
            idx_q      <= '0;
            stim       <= '0;
            live_err_q <= '0;
            live_ff_q  <= '0;
            live_fv_q  <= 1'b0;
          end
        end else begin
          idx_q <= idx_nxt;
          stim  <= pat_nxt;
        end
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

endmodule
